mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin arbiter and select sequencer for the 8-to-1 single-bit multiplexer datapath. It shares the mux among eight requesters and registers a one-hot grant plus the 3-bit select. The selected data bit is forwarded to a single output. It sits directly in front of a `mux8to1` instance, which it instantiates and drives.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive cycles one owner keeps the grant while others wait. Only used with the hold-limit feature. Legal range 1..255.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to `clk`.
- `req` input 8: per-requester request; `req[i]` is level, held until served.
- `din` input 8: per-requester data bit; `din[i]` is routed when `i` is granted.
- `grant` output 8: registered one-hot grant; all-zero when idle.
- `sel` output 3: registered binary index of the owner. Drives mux `S2..S0` (`sel[2]` = `S2`).
- `valid` output 1: registered; 1 when `grant` is non-zero.
- `y` output 1: mux output, equal to `din[sel]`. Combinational from `din`, registered `sel`.

## Operation
- State machine, two states.
  - IDLE: no owner.
  - BUSY: owner = `sel`.
- Pointer `ptr` (3 bits) holds the highest-priority index for the next pick.
- Pick function: first set `req` bit scanning `ptr`, `ptr+1`, …, `ptr+7`, modulo 8 (wrap 7→0).
- IDLE with `req != 0` → BUSY.
  - `grant <= onehot(pick)`, `sel <= pick`, `valid <= 1`, `ptr <= pick+1` (mod 8), `hold_cnt <= 1`.
- IDLE with `req == 0` → stay IDLE; outputs unchanged (zero).
- BUSY, `req[sel]` still high, no forced release → stay; `hold_cnt` saturates at `MAX_HOLD`.
- BUSY, `req[sel]` low → release.
  - Other request pending → re-grant `pick` on the same edge, with no idle bubble.
  - None pending → IDLE: `grant <= 0`, `valid <= 0`, `sel` keeps its last value.
- Forced release (feature enabled): `hold_cnt == MAX_HOLD` and any other `req` bit set → re-grant `pick` with the owner excluded.
  - The owner's `req` stays high and is served again in its round-robin turn.
- Simultaneous drop of owner and arrival of a new request → treated as a normal release.
- Requests change only the pick; they never glitch `grant` mid-cycle.
- Reset, including mid-BUSY: state IDLE, `grant = 0`, `sel = 0`, `valid = 0`, `ptr = 0`, `hold_cnt = 0`.
  - `y` then equals `din[0]`.

## Timing
- Request-to-grant latency: 1 clock edge. `req` is sampled at edge N and `grant`/`sel`/`valid` update after edge N.
- Release-to-regrant: same edge; owner change takes 1 cycle.
- `y` is valid combinationally in the same cycle `grant` is high.
- Consumers sample `y` on the edge that ends the grant cycle.
- Worst-case wait with all 8 requesting and the feature enabled: 7 × `MAX_HOLD` cycles.

## Configuration
- Macro `MUX_ARB_HOLD_LIMIT_EN`.
- Defined:
  - `hold_cnt` is present.
  - An owner is preempted after `MAX_HOLD` cycles if any other request is pending.
  - Fairness is guaranteed.
- Undefined:
  - No counter; `MAX_HOLD` is ignored.
  - The owner keeps the grant until it drops `req`; other requesters may starve.

## Structure
- Package `mux_arb_pkg` holds:
  - `N_REQ = 8`, `SEL_W = 3`.
  - State typedef `{ARB_IDLE, ARB_BUSY}`.
  - Default `MAX_HOLD` constant.
- Sub-module `rr_pick8`: combinational picker.
  - Inputs `req[7:0]`, `ptr[2:0]`, `mask[7:0]`.
  - Outputs `any`, `idx[2:0]`.
  - Owner exclusion is done via `mask`.
- Top instantiates `rr_pick8` and `mux8to1`.

## Test plan
- Reset mid-grant: while owner = 5, pull `rst_n` low → `grant` = 8'h00, `sel` = 0, `valid` = 0 immediately (before the next edge); `y` = `din[0]`.
- Single request: `req` = 8'h08 from IDLE, `din` = 8'h08 → after 1 edge `grant` = 8'h08, `sel` = 3, `valid` = 1, `y` = 1.
- Release with pending request: owner 2, `req` goes 8'h04 → 8'h20 on one edge → next cycle `grant` = 8'h20, `sel` = 5, with no `valid` = 0 cycle.
- Wrap-around: `ptr` = 0 after owner 7, `req` = 8'h41 → grant index 0, then index 6 after 0 releases.
- Hold limit, macro defined, `MAX_HOLD` = 4, `req` = 8'hFF constant → grants 0,1,2,…,7,0, each exactly 4 cycles.
- Macro undefined, `req` = 8'hFF constant for 50 cycles → `grant` stays 8'h01 throughout.

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// mux_arb_pkg: shared constants, state type and helpers for the 8-requester
// round-robin arbiter in front of the 8-to-1 single-bit mux.
package mux_arb_pkg;

  localparam int N_REQ        = 8;
  localparam int SEL_W        = 3;
  localparam int MAX_HOLD_DEF = 4;
  // Hold counter is wide enough for the largest legal MAX_HOLD (255).
  localparam int HOLD_W       = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Binary index to one-hot requester vector.
  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    onehot8 = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: request/data bus from the requesters and the grant,
// select and muxed data bit returned by the arbiter.
interface mux8_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] din;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             y;

  // Requester side.
  modport master (
    output req,
    output din,
    input  grant,
    input  sel,
    input  valid,
    input  y
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  din,
    output grant,
    output sel,
    output valid,
    output y
  );

endinterface

// File: rtl/mux8_rr_arbiter_sub.sv
// Leaf blocks of the arbiter: rr_pick8 (combinational round-robin picker)
// and mux8to1 (8-to-1 single-bit multiplexer driven by the select).
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] cand_s;
  logic             found_s;
  logic [SEL_W-1:0] pos_s;

  assign cand_s = req & mask;
  assign any    = |cand_s;

  // Scan ptr, ptr+1, ... (3-bit wrap) and take the first candidate found.
  always_comb begin
    idx     = {SEL_W{1'b0}};
    found_s = 1'b0;
    pos_s   = {SEL_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      pos_s = ptr + SEL_W'(k);
      if (!found_s && cand_s[pos_s]) begin
        idx     = pos_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

module mux8to1
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] d_i,
  input  logic [SEL_W-1:0] s_i,   // s_i[2] = S2
  output logic             y_o
);

  assign y_o = d_i[s_i];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter sharing an 8-to-1 single-bit mux among
// eight level requesters. Grant, select and valid are registered; y is the
// mux output for the current select.
// Optional feature macro: MUX_ARB_HOLD_LIMIT_EN -- when defined, an owner is
// preempted after MAX_HOLD consecutive cycles if another request is pending.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
)(
  input  logic                    clk,
  input  logic                    rst_n,
  mux8_rr_arbiter_if.slave        bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              at_limit_s;
`endif

  logic [N_REQ-1:0] owner_oh_s;
  logic [N_REQ-1:0] mask_s;
  logic             owner_req_s;
  logic             force_s;
  logic             pick_any_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             y_s;

  assign owner_oh_s  = onehot8(sel_q);
  assign owner_req_s = bus.req[sel_q];

  // While busy the owner is never a candidate: a pick is only used on release
  // or preemption, and in both cases the grant must move elsewhere.
  always_comb begin
    if (state_q == ARB_BUSY) begin
      mask_s = ~owner_oh_s;
    end else begin
      mask_s = {N_REQ{1'b1}};
    end
  end

  rr_pick8 u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .mask (mask_s),
    .any  (pick_any_s),
    .idx  (pick_idx_s)
  );

`ifdef MUX_ARB_HOLD_LIMIT_EN
  assign at_limit_s = (hold_cnt_q == HOLD_W'(MAX_HOLD));
  assign force_s    = at_limit_s && pick_any_s;
`else
  assign force_s    = 1'b0;
`endif

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_d = ARB_BUSY;
          grant_d = onehot8(pick_idx_s);
          sel_d   = pick_idx_s;
          valid_d = 1'b1;
          ptr_d   = pick_idx_s + 3'd1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hold_cnt_d = 8'd1;
`endif
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (!owner_req_s || force_s) begin
          if (pick_any_s) begin
            // Hand over on the same edge, no idle bubble.
            state_d = ARB_BUSY;
            grant_d = onehot8(pick_idx_s);
            sel_d   = pick_idx_s;
            valid_d = 1'b1;
            ptr_d   = pick_idx_s + 3'd1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt_d = 8'd1;
`endif
          end else begin
            // Owner dropped and nobody waits: sel keeps its last value.
            state_d = ARB_IDLE;
            grant_d = {N_REQ{1'b0}};
            valid_d = 1'b0;
          end
        end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
          if (!at_limit_s) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
`else
          state_d = ARB_BUSY;
`endif
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = {N_REQ{1'b0}};
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything including mid-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= {N_REQ{1'b0}};
      sel_q   <= {SEL_W{1'b0}};
      valid_q <= 1'b0;
      ptr_q   <= {SEL_W{1'b0}};
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= {HOLD_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  mux8to1 u_mux (
    .d_i (bus.din),
    .s_i (sel_q),
    .y_o (y_s)
  );

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.y     = y_s;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed and random requests; a reference model
// predicts grant/sel/valid per edge into a queue that a negedge monitor
// pops and compares, including y against din[sel].
module tb_mux8_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux8_rr_arbiter_if bus();

  mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester with r set, scanning start, start+1, ... mod 8, skipping one.
  function automatic int find_next(input logic [7:0] r, input int start, input int skip);
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (start + k) % N_REQ;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
  endtask

  task automatic model_give(input int p);
    m_busy = 1; m_owner = p; m_ptr = (p + 1) % N_REQ; m_hold = 1;
  endtask

  task automatic model_step(input logic [7:0] r);
    int p;
    if (!m_busy) begin
      p = find_next(r, m_ptr, -1);
      if (p >= 0) model_give(p);
    end else if (!r[m_owner]) begin
      p = find_next(r, m_ptr, m_owner);
      if (p >= 0) model_give(p);
      else m_busy = 0;
    end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
      p = find_next(r, m_ptr, m_owner);
      if (m_hold == MH && p >= 0) model_give(p);
      else if (m_hold < MH) m_hold = m_hold + 1;
`endif
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.grant = 8'h00;
    if (m_busy) e.grant[m_owner] = 1'b1;
    e.sel   = 3'(m_owner);
    e.valid = m_busy;
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, model the edge, queue the expectation.
  task automatic cycle(input logic [7:0] r, input logic [7:0] d);
    bus.req = r;
    bus.din = d;
    @(posedge clk);
    model_step(r);
    push_expected();
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant", bus.grant, e.grant);
      check("sel",   {5'b0, bus.sel}, {5'b0, e.sel});
      check("valid", {7'b0, bus.valid}, {7'b0, e.valid});
      check("y",     {7'b0, bus.y}, {7'b0, bus.din[e.sel]});
    end
  end

  initial begin
    logic [7:0] r;
    int mode;
    bus.req = 8'h00;
    bus.din = 8'h01;
    model_reset();
    #3;
    check("rst_grant", bus.grant, 8'h00);
    check("rst_sel",   {5'b0, bus.sel}, 8'h00);
    check("rst_valid", {7'b0, bus.valid}, 8'h00);
    check("rst_y",     {7'b0, bus.y}, 8'h01);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from idle
    cycle(8'h08, 8'h08);
    check("single_grant", bus.grant, 8'h08);
    check("single_sel",   {5'b0, bus.sel}, 8'h03);
    check("single_valid", {7'b0, bus.valid}, 8'h01);
    check("single_y",     {7'b0, bus.y}, 8'h01);
    cycle(8'h00, 8'h00);
    check("idle_valid", {7'b0, bus.valid}, 8'h00);
    check("idle_sel_kept", {5'b0, bus.sel}, 8'h03);

    // Release with a pending request: no valid=0 gap
    cycle(8'h04, 8'h00);
    check("own2_grant", bus.grant, 8'h04);
    cycle(8'h04, 8'h00);
    cycle(8'h20, 8'h20);
    check("handover_grant", bus.grant, 8'h20);
    check("handover_valid", {7'b0, bus.valid}, 8'h01);

    // Wrap-around: owner 7 leaves ptr at 0
    cycle(8'h80, 8'hFF);
    check("own7_sel", {5'b0, bus.sel}, 8'h07);
    cycle(8'h41, 8'h01);
    check("wrap_sel0", {5'b0, bus.sel}, 8'h00);
    cycle(8'h40, 8'h40);
    check("wrap_sel6", {5'b0, bus.sel}, 8'h06);
    cycle(8'h00, 8'h00);

    // Reset while owner 5 holds the grant
    cycle(8'h20, 8'hA5);
    check("pre_rst_sel", {5'b0, bus.sel}, 8'h05);
    @(negedge clk);
    #2;
    bus.din = 8'h5B;
    rst_n = 1'b0;
    #1;
    check("midrst_grant", bus.grant, 8'h00);
    check("midrst_sel",   {5'b0, bus.sel}, 8'h00);
    check("midrst_valid", {7'b0, bus.valid}, 8'h00);
    check("midrst_y",     {7'b0, bus.y}, 8'h01);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    check("inrst_grant", bus.grant, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesting continuously
    for (int c = 0; c < 50; c++) begin
      cycle(8'hFF, 8'($urandom));
`ifndef MUX_ARB_HOLD_LIMIT_EN
      check("starve_grant", bus.grant, 8'h01);
`endif
    end
    cycle(8'h00, 8'h00);

    // Random traffic; the owner tends to keep its request for a while
    for (int c = 0; c < 400; c++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0) r = 8'h00;
      else if (mode < 4) r = 8'h01 << $urandom_range(0, 7);
      else r = 8'($urandom);
      if (m_busy && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      cycle(r, 8'($urandom));
    end
    cycle(8'h00, 8'h00);
    cycle(8'h00, 8'h00);
    @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
